seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 36 +++
 rtl/hex7seg_decoder.sv | 31 +++
 rtl/seg_scan_driver.sv | 110 +++++++++++
 tb/tb_seg_scan_driver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
// Segment codes are active-low with bit7 = decimal point (off).
package seg_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [7:0] SEG_OFF   = 8'hFF;
   localparam logic [3:0] ANODE_OFF = 4'hF;

   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;
   localparam logic [7:0] SEG_A = 8'h88;
   localparam logic [7:0] SEG_B = 8'h83;
   localparam logic [7:0] SEG_C = 8'hC6;
   localparam logic [7:0] SEG_D = 8'hA1;
   localparam logic [7:0] SEG_E = 8'h86;
   localparam logic [7:0] SEG_F = 8'h8E;

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] value;
      logic [NUM_DIGITS-1:0]   dp;
   } disp_word_t;

   function automatic logic [3:0] anode_select(input logic [1:0] index);
      return ~(4'b0001 << index);
   endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-low seven-segment decoder (bits g..a).
module hex7seg_decoder
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_OFF[6:0];
      case (nibble)
         4'h0: seg_n = SEG_0[6:0];
         4'h1: seg_n = SEG_1[6:0];
         4'h2: seg_n = SEG_2[6:0];
         4'h3: seg_n = SEG_3[6:0];
         4'h4: seg_n = SEG_4[6:0];
         4'h5: seg_n = SEG_5[6:0];
         4'h6: seg_n = SEG_6[6:0];
         4'h7: seg_n = SEG_7[6:0];
         4'h8: seg_n = SEG_8[6:0];
         4'h9: seg_n = SEG_9[6:0];
         4'hA: seg_n = SEG_A[6:0];
         4'hB: seg_n = SEG_B[6:0];
         4'hC: seg_n = SEG_C[6:0];
         4'hD: seg_n = SEG_D[6:0];
         4'hE: seg_n = SEG_E[6:0];
         4'hF: seg_n = SEG_F[6:0];
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with tear-free frame-boundary updates.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits (3..1).
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
)
(
   input  logic        i_mclk,
   input  logic        i_reset,
   input  logic        i_load,
   input  logic [15:0] i_value,
   input  logic [3:0]  i_dp,
   input  logic        i_blank,
   output logic [7:0]  D_seg,
   output logic [3:0]  D_a,
   output logic        o_frame
);

   localparam int               CNT_W    = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] prescale;
   logic [1:0]       digit_idx;
   logic             tick;
   logic             frame_tick;

   disp_word_t       load_word;
   disp_word_t       pending;
   disp_word_t       display;
   logic             pending_valid;

   logic [3:0]       cur_nibble;
   logic [6:0]       cur_code;
   logic [6:0]       seg_bits;
   logic             lead_zero;

   assign tick       = (prescale == CNT_LAST);
   assign frame_tick = tick && (digit_idx == 2'd3);
   assign o_frame    = frame_tick && !i_reset;

   always_ff @(posedge i_mclk) begin
      if (i_reset) begin
         prescale  <= '0;
         digit_idx <= '0;
      end else begin
         prescale <= tick ? '0 : prescale + 1'b1;
         if (tick) begin
            digit_idx <= digit_idx + 2'd1;
         end
      end
   end

   // The visible value only changes on a frame boundary so a frame never mixes
   // two values; a load landing on the boundary itself bypasses the pending slot.
   assign load_word = '{value: i_value, dp: i_dp};

   always_ff @(posedge i_mclk) begin
      if (i_reset) begin
         pending       <= '0;
         pending_valid <= 1'b0;
         display       <= '0;
      end else if (frame_tick) begin
         if (i_load) begin
            display <= load_word;
         end else if (pending_valid) begin
            display <= pending;
         end
         pending_valid <= 1'b0;
      end else if (i_load) begin
         pending       <= load_word;
         pending_valid <= 1'b1;
      end
   end

   assign cur_nibble = display.value[{digit_idx, 2'b00} +: 4];

   hex7seg_decoder u_decoder (
      .nibble (cur_nibble),
      .seg_n  (cur_code)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every more-significant nibble are zero.
   always_comb begin
      lead_zero = 1'b0;
      case (digit_idx)
         2'd1:    lead_zero = (display.value[15:4] == 12'h000);
         2'd2:    lead_zero = (display.value[15:8] == 8'h00);
         2'd3:    lead_zero = (display.value[15:12] == 4'h0);
         default: lead_zero = 1'b0;
      endcase
   end
`else
   assign lead_zero = 1'b0;
`endif

   assign seg_bits = lead_zero ? 7'h7F : cur_code;

   always_ff @(posedge i_mclk) begin
      if (i_reset || i_blank) begin
         D_a   <= ANODE_OFF;
         D_seg <= SEG_OFF;
      end else begin
         D_a   <= anode_select(digit_idx);
         D_seg <= {~display.dp[digit_idx], seg_bits};
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (REFRESH_DIV = 4, one frame = 16 cycles).
// Expectations follow LEADING_ZERO_BLANK_EN when the macro is defined.
module tb_seg_scan_driver;

   typedef struct {
      logic [3:0] a;
      logic [7:0] seg;
      logic       frame;
   } exp_t;

   localparam logic [7:0] HEX_TBL [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   logic        i_mclk;
   logic        i_reset;
   logic        i_load;
   logic [15:0] i_value;
   logic [3:0]  i_dp;
   logic        i_blank;
   logic [7:0]  D_seg;
   logic [3:0]  D_a;
   logic        o_frame;

   int   checks;
   int   failures;
   exp_t sb[$];

   seg_scan_driver #(.REFRESH_DIV(4)) dut (
      .i_mclk  (i_mclk),
      .i_reset (i_reset),
      .i_load  (i_load),
      .i_value (i_value),
      .i_dp    (i_dp),
      .i_blank (i_blank),
      .D_seg   (D_seg),
      .D_a     (D_a),
      .o_frame (o_frame)
   );

   initial i_mclk = 1'b0;
   always #5 i_mclk = ~i_mclk;

   function automatic logic [6:0] exp_code(input logic [15:0] v, input int d);
      logic [7:0] code;
`ifdef LEADING_ZERO_BLANK_EN
      logic [15:0] upper;
      upper = v >> (4 * d);
      if (d > 0 && upper == 16'h0000) return 7'h7F;
`endif
      code = HEX_TBL[v[4*d +: 4]];
      return code[6:0];
   endfunction

   task automatic step();
      @(posedge i_mclk);
      @(negedge i_mclk);
   endtask

   // Starts right after a boundary edge; the 16th step lands on the next boundary edge.
   task automatic drive_frame(input string name, input logic [15:0] val, input logic [3:0] dp,
                              input logic blank, input int la, input logic [15:0] lav,
                              input int lb, input logic [15:0] lbv, input logic [3:0] ldp);
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         int d;
         d       = i / 4;
         e.a     = blank ? 4'hF : ~(4'b0001 << d);
         e.seg   = blank ? 8'hFF : {~dp[d], exp_code(val, d)};
         e.frame = (i == 14);
         sb.push_back(e);
      end
      for (int i = 0; i < 16; i++) begin
         i_blank = blank;
         if (i == la) begin
            i_load = 1'b1; i_value = lav; i_dp = ldp;
         end else if (i == lb) begin
            i_load = 1'b1; i_value = lbv; i_dp = ldp;
         end
         step();
         i_load = 1'b0;
         e = sb.pop_front();
         checks++;
         if (D_a !== e.a || D_seg !== e.seg || o_frame !== e.frame) begin
            failures++;
            $display("[TB] FAIL %s[%0d]: got D_a=%h D_seg=%h o_frame=%b, expected D_a=%h D_seg=%h o_frame=%b",
                     name, i, D_a, D_seg, o_frame, e.a, e.seg, e.frame);
         end
      end
      i_blank = 1'b0;
   endtask

   task automatic wait_frame(input string name);
      bit found;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         if (o_frame === 1'b1) found = 1'b1;
         else step();
      end
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL %s: o_frame=%b after 40 cycles, expected a pulse", name, o_frame);
      end
      step();
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_load = 1'b0; i_value = '0; i_dp = '0; i_blank = 1'b0;
      repeat (2) @(posedge i_mclk);
      @(negedge i_mclk);
      checks++;
      if (D_a !== 4'hF || D_seg !== 8'hFF || o_frame !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_hold: got D_a=%h D_seg=%h o_frame=%b, expected F FF 0", D_a, D_seg, o_frame);
      end
      i_reset = 1'b0;
      step();
      checks++;
      if (D_a !== 4'hE || D_seg !== 8'hC0 || o_frame !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_first_digit: got D_a=%h D_seg=%h o_frame=%b, expected E C0 0", D_a, D_seg, o_frame);
      end
      wait_frame("reset_align");
   endtask

   task automatic test_scan();
      drive_frame("scan_pre", 16'h0000, 4'h0, 1'b0, 2, 16'h1234, -1, 16'h0, 4'h0);
      drive_frame("scan", 16'h1234, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0);
   endtask

   task automatic test_tear_free();
      drive_frame("tear_hold", 16'h1234, 4'h0, 1'b0, 5, 16'hABCD, -1, 16'h0, 4'h0);
      drive_frame("tear_new", 16'hABCD, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0);
   endtask

   task automatic test_coincident();
      drive_frame("coinc_pre", 16'hABCD, 4'h0, 1'b0, 15, 16'h00FF, -1, 16'h0, 4'h0);
      drive_frame("coinc_shown", 16'h00FF, 4'h0, 1'b0, 3, 16'h1111, 9, 16'h2222, 4'h0);
      drive_frame("latest_wins", 16'h2222, 4'h0, 1'b0, 5, 16'h3333, 15, 16'h4444, 4'h0);
      drive_frame("coinc_over", 16'h4444, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0);
      drive_frame("flag_clear", 16'h4444, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0);
   endtask

   task automatic test_reset_mid();
      i_load = 1'b1; i_value = 16'h7777; i_dp = 4'h0;
      step();
      i_reset = 1'b1; i_load = 1'b1; i_value = 16'hFFFF; i_dp = 4'hF;
      step();
      i_load = 1'b0;
      checks++;
      if (D_a !== 4'hF || D_seg !== 8'hFF || o_frame !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid: got D_a=%h D_seg=%h o_frame=%b, expected F FF 0", D_a, D_seg, o_frame);
      end
      i_reset = 1'b0;
      step();
      checks++;
      if (D_a !== 4'hE || D_seg !== 8'hC0) begin
         failures++;
         $display("[TB] FAIL reset_mid_clear: got D_a=%h D_seg=%h, expected E C0", D_a, D_seg);
      end
      wait_frame("reset_mid_align");
      drive_frame("after_reset", 16'h0000, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0);
   endtask

   task automatic test_blank_dp();
      drive_frame("blank", 16'h0000, 4'h0, 1'b1, 4, 16'h0000, -1, 16'h0, 4'b0001);
      drive_frame("dp", 16'h0000, 4'b0001, 1'b0, 2, 16'h0005, -1, 16'h0, 4'h0);
   endtask

   task automatic test_leading_zero();
      drive_frame("lzb", 16'h0005, 4'h0, 1'b0, 6, 16'h0000, -1, 16'h0, 4'b1000);
      drive_frame("lzb_dp", 16'h0000, 4'b1000, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_scan();
      test_tear_free();
      test_coincident();
      test_reset_mid();
      test_blank_dp();
      test_leading_zero();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
